// File: rtl/dsp_cfg_pkg.sv
// Shared types and constants for the DSP column configuration-frame sequencer.
package dsp_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      DISCARD = 3'd2,
      SETUP   = 3'd3,
      STROBE  = 3'd4,
      HOLD    = 3'd5
   } state_t;

   // Header layout: frame address sits in the low bits, upper bits are ignored.
   localparam int HDR_ADDR_LSB = 0;

   function automatic int addr_width(input int frames);
      return (frames > 1) ? $clog2(frames) : 1;
   endfunction

   function automatic int row_cnt_width(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/dsp_frame_config_ctrl_frame_strobe_decoder.sv
// One-hot frame strobe decoder; output is zero when disabled or addr is out of range.
module frame_strobe_decoder #(
   parameter int MaxFramesPerCol = 20,
   parameter int AW              = 5
) (
   input  logic [AW-1:0]              addr,
   input  logic                       en,
   output logic [MaxFramesPerCol-1:0] strobe
);

   always_comb begin
      strobe = '0;
      for (int i = 0; i < MaxFramesPerCol; i++) begin
         strobe[i] = en && (addr == AW'(i));
      end
   end

endmodule

// File: rtl/dsp_frame_config_ctrl.sv
// Configuration-frame sequencer: header + NumRows data words, then a single
// FrameStrobe pulse framed by one setup and one hold cycle.
module dsp_frame_config_ctrl
   import dsp_cfg_pkg::*;
#(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int NumRows         = 2
) (
   input  logic                                 UserCLK,
   input  logic                                 reset,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [FrameBitsPerRow-1:0]           s_data,
   output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
   output logic [MaxFramesPerCol-1:0]           FrameStrobe,
   output logic                                 busy,
   output logic                                 frame_done,
   output logic                                 addr_err,
   input  logic                                 err_clr,
   output state_t                               dbg_state
);

   localparam int AW = addr_width(MaxFramesPerCol);
   localparam int RW = row_cnt_width(NumRows);

   // Handshake: a word transfers on a rising edge where s_valid and s_ready are
   // both high; s_ready depends only on state and reset, never on s_valid.

   state_t                     state;
   state_t                     next_state;
   logic [AW-1:0]              addr;
   logic [AW-1:0]              hdr_addr;
   logic [RW-1:0]              row_cnt;
   logic                       accept;
   logic                       hdr_ok;
   logic                       last_row;
   logic [MaxFramesPerCol-1:0] strobe_next;

   assign accept    = s_valid & s_ready;
   assign hdr_addr  = s_data[HDR_ADDR_LSB +: AW];
   assign hdr_ok    = ({1'b0, hdr_addr} < (AW+1)'(MaxFramesPerCol));
   assign last_row  = (row_cnt == RW'(NumRows - 1));
   assign dbg_state = state;

   always_ff @(posedge UserCLK) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = hdr_ok ? LOAD : DISCARD;
         LOAD:    if (accept && last_row) next_state = SETUP;
         DISCARD: if (accept && last_row) next_state = IDLE;
         SETUP:   next_state = STROBE;
         STROBE:  next_state = HOLD;
         HOLD:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      s_ready = !reset && ((state == IDLE) || (state == LOAD) || (state == DISCARD));
   end

   // Strobe is decoded from next_state so the registered output lines up with STROBE.
   frame_strobe_decoder #(
      .MaxFramesPerCol(MaxFramesPerCol),
      .AW             (AW)
   ) u_decoder (
      .addr  (addr),
      .en    (next_state == STROBE),
      .strobe(strobe_next)
   );

   always_ff @(posedge UserCLK) begin
      if (reset) begin
         addr        <= '0;
         row_cnt     <= '0;
         FrameData   <= '0;
         FrameStrobe <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         addr_err    <= 1'b0;
      end else begin
         if (state == IDLE && accept) begin
            row_cnt <= '0;
            if (hdr_ok) addr <= hdr_addr;
         end
         if ((state == LOAD || state == DISCARD) && accept) begin
            row_cnt <= last_row ? '0 : row_cnt + RW'(1);
         end
         if (state == LOAD && accept) begin
            for (int r = 0; r < NumRows; r++) begin
               if (row_cnt == RW'(r)) FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
            end
         end
         FrameStrobe <= strobe_next;
         busy        <= (next_state != IDLE);
         frame_done  <= (next_state == HOLD);
         if (state == IDLE && accept && !hdr_ok) addr_err <= 1'b1;
         else if (err_clr)                       addr_err <= 1'b0;
      end
   end

endmodule
